// File: rtl/vec_sweep_capture.sv
// vec_sweep_capture: clocked self-test sequencer for a 4-input combinational
// circuit. It steps {a,b,c,d} through 0..15 and holds each vector for SETTLE
// cycles. It then samples the circuit output once per vector and builds a
// 16-bit truth-table signature. The signature is scored against EXPECTED.
module vec_sweep_capture #(
  parameter int          SETTLE   = 2,
  parameter logic [15:0] EXPECTED = 16'hE111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [3:0]  vec_out,
  input  logic        dut_o,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic        pass,
  output logic [4:0]  mismatch_cnt,
  output logic [3:0]  first_fail
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Counter reload value: the counter runs SETTLE-1 down to 0, so a vector
  // occupies SETTLE cycles of SETTLE plus one cycle of SAMPLE.
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  vec_q, vec_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;
  logic        pass_q, pass_d;
  logic [4:0]  mm_q, mm_d;
  logic [3:0]  ff_q, ff_d;

  // The sample differs from the golden bit for the vector currently applied.
  logic        miss;
  assign miss = dut_o ^ EXPECTED[vec_q];

  // State register and datapath registers; reset takes priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      vec_q    <= 4'd0;
      cnt_q    <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
      pass_q   <= 1'b0;
      mm_q     <= 5'd0;
      ff_q     <= 4'd0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      pass_q   <= pass_d;
      mm_q     <= mm_d;
      ff_q     <= ff_d;
    end
  end

  // Next-state logic: a start is accepted only when no sweep is running.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_SETTLE;
      S_SETTLE:       if (cnt_q == 4'd0) state_d = S_SAMPLE;
      S_SAMPLE:       state_d = (vec_q == 4'd15) ? S_DONE : S_SETTLE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Output and datapath updates. The first miss is detected because the
  // mismatch count is still zero when it occurs.
  always_comb begin
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = done_q;
    result_d = result_q;
    pass_d   = pass_q;
    mm_d     = mm_q;
    ff_d     = ff_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          vec_d    = 4'd0;
          cnt_d    = CNT_LOAD;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          result_d = 16'h0000;
          pass_d   = 1'b0;
          mm_d     = 5'd0;
          ff_d     = 4'd0;
        end
      end
      S_SETTLE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
      end
      S_SAMPLE: begin
        result_d[vec_q] = dut_o;
        if (miss) begin
          mm_d = mm_q + 5'd1;
          if (mm_q == 5'd0) ff_d = vec_q;
        end
        if (vec_q == 4'd15) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          pass_d = (mm_d == 5'd0);
        end else begin
          vec_d = vec_q + 4'd1;
          cnt_d = CNT_LOAD;
        end
      end
      default: ;
    endcase
  end

  assign vec_out      = vec_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign result       = result_q;
  assign pass         = pass_q;
  assign mismatch_cnt = mm_q;
  assign first_fail   = ff_q;

endmodule

// File: tb/tb_vec_sweep_capture.sv
// Directed bench for vec_sweep_capture. The bench models the circuit under
// test, including several faulty variants. A second instance runs with SETTLE = 1.
module tb_vec_sweep_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        start1 = 1'b0;
  logic [3:0]  vec_out, vec_out1;
  logic        dut_o, dut_o1;
  logic        busy, done, pass, busy1, done1, pass1;
  logic [15:0] result, result1;
  logic [4:0]  mismatch_cnt, mismatch_cnt1;
  logic [3:0]  first_fail, first_fail1;

  int total = 0;
  int bad   = 0;
  int mode  = 0;   // 0 cir, 1 tied low, 2 inversion removed, 3 cir with vec 5/9 flipped

  always #5 clk = ~clk;

  function automatic logic cir(input logic [3:0] v);
    return (v[3] & v[2]) ^ ~(v[1] | v[0]);
  endfunction

  always_comb begin
    case (mode)
      1:       dut_o = 1'b0;
      2:       dut_o = (vec_out[3] & vec_out[2]) ^ (vec_out[1] | vec_out[0]);
      3:       dut_o = cir(vec_out) ^ ((vec_out == 4'd5) || (vec_out == 4'd9));
      default: dut_o = cir(vec_out);
    endcase
  end
  assign dut_o1 = cir(vec_out1);

  vec_sweep_capture #(.SETTLE(2), .EXPECTED(16'hE111)) u_dut (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec_out), .dut_o(dut_o),
    .busy(busy), .done(done), .result(result), .pass(pass),
    .mismatch_cnt(mismatch_cnt), .first_fail(first_fail)
  );

  vec_sweep_capture #(.SETTLE(1), .EXPECTED(16'hE111)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .vec_out(vec_out1), .dut_o(dut_o1),
    .busy(busy1), .done(done1), .result(result1), .pass(pass1),
    .mismatch_cnt(mismatch_cnt1), .first_fail(first_fail1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start, then follow the sweep to done, checking that vec_out holds
  // each value for three cycles. Optionally re-pulse start at vector 5.
  task automatic sweep(input bit restart_at5, output int cyc);
    bit pulsed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("done_clear_on_start", {31'd0, done}, 32'd0);
    cyc = 0;
    while (!done && cyc < 200) begin
      if (start) start = 1'b0;
      if (restart_at5 && !pulsed && vec_out == 4'd5) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end
      tick();
      cyc++;
      if (!done) begin
        chk("vec_step", {28'd0, vec_out}, 32'(cyc / 3));
        chk("busy_during", {31'd0, busy}, 32'd1);
      end
    end
    start = 1'b0;
    chk("done_latency", 32'(cyc), 32'd48);
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    chk("vec_at_done", {28'd0, vec_out}, 32'd15);
  endtask

  initial begin
    int cyc;
    // Reset for two cycles with start held high: reset must win.
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_vec", {28'd0, vec_out}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_mm", {27'd0, mismatch_cnt}, 32'd0);
    chk("rst_ff", {28'd0, first_fail}, 32'd0);
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Good circuit, with an ignored start at vector 5.
    mode = 0;
    sweep(1'b1, cyc);
    chk("good_result", {16'd0, result}, 32'hE111);
    chk("good_pass", {31'd0, pass}, 32'd1);
    chk("good_mm", {27'd0, mismatch_cnt}, 32'd0);
    chk("good_ff", {28'd0, first_fail}, 32'd0);
    tick();
    tick();
    chk("done_hold", {31'd0, done}, 32'd1);
    chk("done_hold_result", {16'd0, result}, 32'hE111);

    // Output tied low; the run restarts from DONE.
    mode = 1;
    sweep(1'b0, cyc);
    chk("zero_result", {16'd0, result}, 32'h0000);
    chk("zero_pass", {31'd0, pass}, 32'd0);
    chk("zero_mm", {27'd0, mismatch_cnt}, 32'd6);
    chk("zero_ff", {28'd0, first_fail}, 32'd0);

    // Inversion removed: every bit differs.
    mode = 2;
    sweep(1'b0, cyc);
    chk("inv_result", {16'd0, result}, 32'h1EEE);
    chk("inv_pass", {31'd0, pass}, 32'd0);
    chk("inv_mm", {27'd0, mismatch_cnt}, 32'd16);
    chk("inv_ff", {28'd0, first_fail}, 32'd0);

    // Two flipped vectors: the first failure is at 5.
    mode = 3;
    sweep(1'b0, cyc);
    chk("flip_result", {16'd0, result}, 32'hE331);
    chk("flip_pass", {31'd0, pass}, 32'd0);
    chk("flip_mm", {27'd0, mismatch_cnt}, 32'd2);
    chk("flip_ff", {28'd0, first_fail}, 32'd5);

    // Reset mid-sweep at vector 7, then a clean sweep.
    mode = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (vec_out != 4'd7 && cyc < 100) begin
      tick();
      cyc++;
    end
    chk("reach_vec7", {28'd0, vec_out}, 32'd7);
    chk("partial_result", {16'd0, result}, 32'h0011);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_vec", {28'd0, vec_out}, 32'd0);
    chk("abort_result", {16'd0, result}, 32'h0000);
    chk("abort_done", {31'd0, done}, 32'd0);
    sweep(1'b0, cyc);
    chk("resweep_result", {16'd0, result}, 32'hE111);
    chk("resweep_pass", {31'd0, pass}, 32'd1);

    // SETTLE = 1 instance: two cycles per vector.
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("s1_busy", {31'd0, busy1}, 32'd1);
    cyc = 0;
    while (!done1 && cyc < 200) begin
      tick();
      cyc++;
      if (!done1) chk("s1_vec_step", {28'd0, vec_out1}, 32'(cyc / 2));
    end
    chk("s1_latency", 32'(cyc), 32'd32);
    chk("s1_result", {16'd0, result1}, 32'hE111);
    chk("s1_pass", {31'd0, pass1}, 32'd1);
    chk("s1_mm", {27'd0, mismatch_cnt1}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vec_sweep_capture.md
Name: vec_sweep_capture

Overview:
- Self-test stage wrapped around the 4-input gate circuit (cir).
- Upstream side: exhaustively drives the 4-bit input vector {a,b,c,d} through 0..15.
- Downstream side: samples the circuit output o after a settle delay for each vector, assembles a 16-bit truth-table signature, and compares it against an expected signature.
- Replaces the free-running testbench sweep with a synthesizable, clocked sequencer that the top-level or bench starts and polls.

Parameters:
- SETTLE, 2: cycles vec_out is held stable before dut_o is sampled; legal range 1..15.
- EXPECTED, 16'hE111: golden truth table; bit i = required dut_o for vec_out == i. The default matches o = (a&b) ^ ~(c|d).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a sweep; honoured only in IDLE or DONE.
- vec_out  output  4  drives {a,b,c,d} of the DUT; a = vec_out[3], d = vec_out[0].
- dut_o  input  1  DUT output o.
- busy  output  1  high while a sweep is in progress.
- done  output  1  high from sweep completion until the next accepted start or rst.
- result  output  16  captured truth table; bit i = dut_o sampled for vector i.
- pass  output  1  (result == EXPECTED); valid only while done = 1, otherwise 0.
- mismatch_cnt  output  5  popcount(result ^ EXPECTED); range 0..16; valid while done = 1.
- first_fail  output  4  lowest index i where result[i] != EXPECTED[i]; 0 if none.

Behaviour:
- One clock domain; rst is synchronous and active-high. All state is updated on the rising edge of clk only.
- Reset values: state = IDLE; vec_out = 0; busy = 0; done = 0; result = 0; pass = 0; mismatch_cnt = 0; first_fail = 0; settle counter = 0.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- IDLE or DONE, start = 1:
  - go to SETTLE; vec_out <= 0; result <= 0; done <= 0; pass <= 0; mismatch_cnt <= 0; first_fail <= 0; settle counter <= SETTLE-1; busy <= 1.
- SETTLE:
  - If the counter is nonzero, decrement it.
  - If the counter is 0, go to SAMPLE.
  - State occupancy is exactly SETTLE cycles per vector.
- SAMPLE (1 cycle):
  - result[vec_out] <= dut_o.
  - Compare dut_o against EXPECTED[vec_out]. On a difference, increment mismatch_cnt. If this is the first difference in the sweep, also set first_fail <= vec_out.
  - If vec_out == 15: go to DONE; busy <= 0; done <= 1; pass <= (mismatch_cnt_next == 0).
  - Otherwise: vec_out <= vec_out + 1; counter <= SETTLE-1; go to SETTLE.
- DONE:
  - Hold all outputs.
  - vec_out stays at 15.
- Latency: busy rises on the edge after start is sampled; done rises exactly 16*(SETTLE+1) cycles later (48 cycles for SETTLE = 2).
- Sampling timing: dut_o is sampled on the edge that ends the SAMPLE cycle. At that point vec_out has been stable for SETTLE+1 edges.
- start while busy: ignored; no restart and no effect on counters.
- start asserted in the same cycle as rst: rst wins; state = IDLE.
- rst mid-sweep: abort immediately to reset values. A later start begins a fresh sweep from vec 0.
- Width rules:
  - vec_out increments within 4 bits and never wraps during a sweep; the sweep terminates at 15.
  - mismatch_cnt is 5 bits so that the value 16 is representable.
- dut_o is treated as already synchronous to clk. No synchronizer is included.

Test Plan:
- DUT = cir, SETTLE = 2, rst for 2 cycles, then start pulse -> vec_out steps 0..15, each value held 3 cycles; done after 48 cycles; result = 16'hE111; pass = 1; mismatch_cnt = 0; first_fail = 0.
- dut_o tied to 0 -> result = 16'h0000; pass = 0; mismatch_cnt = 6; first_fail = 0.
- DUT with the or_self inversion removed (o = (a&b) ^ (c|d)) -> result = 16'h1EEE; mismatch_cnt = 16; first_fail = 0; pass = 0.
- rst asserted when vec_out = 7 -> next cycle busy = 0, vec_out = 0, result = 0. A subsequent start completes normally with result = 16'hE111.
- start pulsed again at vec_out = 5 -> no effect; done still at cycle 48. A start in DONE clears done and restarts the sweep.
- SETTLE = 1 -> done after 32 cycles; result = 16'hE111.
